grayscale_pipe: RTL and testbench

Parametrised, pipelined RGB-to-grayscale converter with a valid/ready stream interface, runtime-selectable luma coefficient sets and rounded fixed-point arithmetic. It replaces the fixed-width, shift-approximation converter in the colorspace stage. It sits between the pixel input stream and the edge-detection kernels, and tolerates downstream backpressure without dropping or reordering pixels.

---
 rtl/grayscale_pipe.sv | 128 ++++++++++++
 tb/tb_grayscale_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_pipe.sv
// Two-stage RGB-to-luma converter with a valid/ready stream interface,
// runtime-selectable coefficient sets and a rounded, saturated fixed-point sum.
module grayscale_pipe #(
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_COEF_FRAC      = 8
) (
    input  logic                          I_CLK,
    input  logic                          I_RESET,
    input  logic                          I_ENABLE,
    input  logic                          I_VALID,
    output logic                          O_READY,
    input  logic [3*P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
    input  logic [1:0]                    I_MODE,
    input  logic                          I_LAST,
    output logic                          O_VALID,
    input  logic                          I_READY,
    output logic [P_SUBPIXEL_DEPTH-1:0]   O_PIXEL,
    output logic                          O_LAST
);

    localparam int D  = P_SUBPIXEL_DEPTH;
    localparam int PW = D + 9;
    localparam int SW = D + 10;
    localparam logic [SW-1:0] ROUND = SW'(1) << (P_COEF_FRAC - 1);

    logic [D-1:0]  w_red;
    logic [D-1:0]  w_green;
    logic [D-1:0]  w_blue;
    logic [8:0]    w_coefR;
    logic [8:0]    w_coefG;
    logic [8:0]    w_coefB;
    logic [PW-1:0] w_prodR;
    logic [PW-1:0] w_prodG;
    logic [PW-1:0] w_prodB;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_scaled;
    logic [D-1:0]  w_luma;
    logic          w_s1Adv;
    logic          w_s2Adv;
    logic          w_accept;

    logic          r_s1Valid;
    logic [PW-1:0] r_prodR;
    logic [PW-1:0] r_prodG;
    logic [PW-1:0] r_prodB;
    logic          r_s1Last;
    logic          r_s2Valid;
    logic [D-1:0]  r_luma;
    logic          r_s2Last;

    assign w_red   = I_PIXEL[3*D-1:2*D];
    assign w_green = I_PIXEL[2*D-1:D];
    assign w_blue  = I_PIXEL[D-1:0];

    // Each coefficient set sums to 256 so full-scale white maps to full-scale luma.
    always_comb begin
        w_coefR = 9'd77;
        w_coefG = 9'd150;
        w_coefB = 9'd29;
        case (I_MODE)
            2'd1: begin
                w_coefR = 9'd54;
                w_coefG = 9'd183;
                w_coefB = 9'd19;
            end
            2'd2: begin
                w_coefR = 9'd85;
                w_coefG = 9'd86;
                w_coefB = 9'd85;
            end
            2'd3: begin
                w_coefR = 9'd0;
                w_coefG = 9'd256;
                w_coefB = 9'd0;
            end
            default: ;
        endcase
    end

    assign w_prodR = PW'(w_red)   * PW'(w_coefR);
    assign w_prodG = PW'(w_green) * PW'(w_coefG);
    assign w_prodB = PW'(w_blue)  * PW'(w_coefB);

    assign w_sum    = SW'(r_prodR) + SW'(r_prodG) + SW'(r_prodB) + ROUND;
    assign w_scaled = w_sum >> P_COEF_FRAC;
    assign w_luma   = (|w_scaled[SW-1:D]) ? {D{1'b1}} : w_scaled[D-1:0];

    // A stage may load whenever it is empty or its occupant leaves this cycle.
    assign w_s2Adv  = ~r_s2Valid | I_READY;
    assign w_s1Adv  = ~r_s1Valid | w_s2Adv;
    assign O_READY  = I_ENABLE & ~I_RESET & w_s1Adv;
    assign w_accept = I_VALID & O_READY;

    assign O_VALID = r_s2Valid & I_ENABLE;
    assign O_PIXEL = r_luma;
    assign O_LAST  = r_s2Last;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_luma    <= '0;
            r_s2Last  <= 1'b0;
        end else if (I_ENABLE) begin
            if (w_s1Adv) begin
                r_s1Valid <= w_accept;
            end
            if (w_s2Adv) begin
                r_s2Valid <= r_s1Valid;
            end
            if (w_s2Adv && r_s1Valid) begin
                r_luma   <= w_luma;
                r_s2Last <= r_s1Last;
            end
        end
    end

    // Stage-1 payload needs no reset; its valid flag qualifies it.
    always_ff @(posedge I_CLK) begin
        if (w_accept) begin
            r_prodR  <= w_prodR;
            r_prodG  <= w_prodG;
            r_prodB  <= w_prodB;
            r_s1Last <= I_LAST;
        end
    end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Scoreboard bench for grayscale_pipe: stimulus pushes model results on accept,
// a negedge monitor pops them as the converter emits pixels.
module tb_grayscale_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        iValid;
    logic        oReady;
    logic [23:0] iPixel;
    logic [1:0]  iMode;
    logic        iLast;
    logic        oValid;
    logic        iReady;
    logic [7:0]  oPixel;
    logic        oLast;

    typedef struct {
        logic [7:0] pix;
        logic       last;
        int         acc;
    } expEntry_t;

    expEntry_t   sbQ[$];
    expEntry_t   headEntry;
    expEntry_t   newEntry;
    int          nChecks = 0;
    int          nPass = 0;
    int          enCycle = 0;
    int          qSize;
    bit          monitorOn = 0;
    bit          latencyCheck = 0;
    bit          prevStall = 0;
    bit          randomDone = 0;
    logic [7:0]  prevPix;
    logic        expReady;
    logic        expValid;
    logic [23:0] modeZeroPix [4] = '{24'hFFFFFF, 24'hFF0000, 24'h000080, 24'h000000};
    logic [23:0] sweepPix [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};

    always #5 clk = ~clk;

    grayscale_pipe #(.P_SUBPIXEL_DEPTH(8), .P_COEF_FRAC(8)) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .I_ENABLE(enable),
        .I_VALID (iValid),
        .O_READY (oReady),
        .I_PIXEL (iPixel),
        .I_MODE  (iMode),
        .I_LAST  (iLast),
        .O_VALID (oValid),
        .I_READY (iReady),
        .O_PIXEL (oPixel),
        .O_LAST  (oLast)
    );

    // Reference luma: weighted sum with rounding to nearest, clamped to 8 bits.
    function automatic logic [7:0] refGray(input logic [23:0] pix, input logic [1:0] mode);
        int cr, cg, cb, y;
        case (mode)
            2'd0:    begin cr = 77; cg = 150; cb = 29; end
            2'd1:    begin cr = 54; cg = 183; cb = 19; end
            2'd2:    begin cr = 85; cg = 86;  cb = 85; end
            default: begin cr = 0;  cg = 256; cb = 0;  end
        endcase
        y = (int'(pix[23:16]) * cr + int'(pix[15:8]) * cg + int'(pix[7:0]) * cb + 128) / 256;
        if (y > 255) y = 255;
        return 8'(y);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    always @(posedge clk) begin
        if (enable && !rst) enCycle <= enCycle + 1;
    end

    // Pipeline occupancy equals the number of accepted-but-unemitted pixels in the queue.
    always @(negedge clk) begin
        if (monitorOn) begin
            qSize = sbQ.size();
            expReady = enable && !rst && (qSize < 2 || iReady);
            checkOutput("oReady", 32'(oReady), 32'(expReady));
            expValid = 1'b0;
            if (qSize >= 2) expValid = enable;
            else if (qSize == 1) expValid = enable && (enCycle - sbQ[0].acc >= 2);
            checkOutput("oValid", 32'(oValid), 32'(expValid));
            if (prevStall && oValid) checkOutput("stablePixel", 32'(oPixel), 32'(prevPix));
            prevStall = oValid && !iReady;
            prevPix = oPixel;
            if (rst) begin
                sbQ.delete();
            end else begin
                if (oValid && iReady) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpectedOutput", 32'(sbQ.size()), 32'(1));
                    end else begin
                        headEntry = sbQ.pop_front();
                        checkOutput("pixel", 32'(oPixel), 32'(headEntry.pix));
                        checkOutput("last", 32'(oLast), 32'(headEntry.last));
                        if (latencyCheck) checkOutput("latency", 32'(enCycle - headEntry.acc), 32'(2));
                    end
                end
                if (iValid && oReady) begin
                    newEntry.pix = refGray(iPixel, iMode);
                    newEntry.last = iLast;
                    newEntry.acc = enCycle;
                    sbQ.push_back(newEntry);
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [23:0] pix, input logic [1:0] mode, input logic last);
        bit ok = 0;
        iValid = 1'b1;
        iPixel = pix;
        iMode = mode;
        iLast = last;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (oReady === 1'b1) ok = 1;
        end
        @(posedge clk);
        #1;
        iValid = 1'b0;
        checkOutput("accepted", 32'(ok), 32'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sbQ.size() != 0; k++) stepCycle();
        checkOutput("drainEmpty", 32'(sbQ.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        iValid = 1'b0;
        iReady = 1'b1;
        iPixel = '0;
        iMode = '0;
        iLast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        monitorOn = 1;
        @(negedge clk);
        checkOutput("resetValid", 32'(oValid), 32'(0));
        checkOutput("resetPixel", 32'(oPixel), 32'(0));
        checkOutput("resetLast", 32'(oLast), 32'(0));
        checkOutput("resetReady", 32'(oReady), 32'(1));
        stepCycle();

        $display("[TB] mode 0 values and sweep across modes 1-3");
        latencyCheck = 1;
        for (int i = 0; i < 4; i++) applyStimulus(modeZeroPix[i], 2'd0, 1'b0);
        drain();
        for (int p = 0; p < 3; p++)
            for (int m = 1; m <= 3; m++) applyStimulus(sweepPix[p], 2'(m), 1'b0);
        drain();
        latencyCheck = 0;

        $display("[TB] backpressure on incrementing grays");
        fork
            begin
                for (int i = 1; i <= 8; i++) applyStimulus({3{8'(i)}}, 2'd0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 iReady = 1'b0;
                repeat (4) @(posedge clk);
                #1 iReady = 1'b1;
            end
        join
        drain();

        $display("[TB] end-of-line marker under a short stall");
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(24'($urandom), 2'd0, 1'(i == 3));
            end
            begin
                repeat (4) @(posedge clk);
                #1 iReady = 1'b0;
                repeat (2) @(posedge clk);
                #1 iReady = 1'b1;
            end
        join
        drain();

        $display("[TB] global enable held low with two pixels in flight");
        applyStimulus(24'h406080, 2'd0, 1'b0);
        applyStimulus(24'hC0A020, 2'd1, 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iValid = 1'b1;
            iPixel = 24'($urandom);
            @(negedge clk);
            checkOutput("disabledValid", 32'(oValid), 32'(0));
            checkOutput("disabledReady", 32'(oReady), 32'(0));
            stepCycle();
        end
        iValid = 1'b0;
        enable = 1'b1;
        drain();

        $display("[TB] reset pulse with both stages full");
        iReady = 1'b0;
        applyStimulus(24'h123456, 2'd1, 1'b1);
        applyStimulus(24'h654321, 2'd2, 1'b0);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("pulseValid", 32'(oValid), 32'(0));
        checkOutput("pulsePixel", 32'(oPixel), 32'(0));
        checkOutput("pulseLast", 32'(oLast), 32'(0));
        stepCycle();
        iReady = 1'b1;
        latencyCheck = 1;
        applyStimulus(24'hFFFFFF, 2'd0, 1'b0);
        drain();
        latencyCheck = 0;

        $display("[TB] randomized traffic with random backpressure and stalls");
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(3) == 0) stepCycle();
                    applyStimulus(24'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)));
                end
                randomDone = 1;
            end
            begin
                while (!randomDone) begin
                    iReady = ($urandom_range(3) != 0);
                    enable = ($urandom_range(15) != 0);
                    stepCycle();
                end
                iReady = 1'b1;
                enable = 1'b1;
            end
        join
        iReady = 1'b1;
        enable = 1'b1;
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
